// File: rtl/gpio_in_pkg.sv
// Shared constants for the input GPIO responder: bus word map, data width and
// the debounce counter sizing helper.
package gpio_in_pkg;

  localparam int BUS_W = 32;

  localparam logic [1:0] GPIO_IN_ADDR_DATA = 2'd0;
  localparam logic [1:0] GPIO_IN_ADDR_RISE = 2'd1;
  localparam logic [1:0] GPIO_IN_ADDR_FALL = 2'd2;
  localparam logic [1:0] GPIO_IN_ADDR_PEND = 2'd3;

  // A 1-cycle filter still needs a 1-bit counter so the port widths stay legal.
  function automatic int cnt_w(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/gpio_in_if.sv
// Core peripheral bus slice seen by gpio_in: request/grant handshake plus
// word-addressed read/write data.
interface gpio_in_if;
  import gpio_in_pkg::*;

  logic             ce;
  logic             req;
  logic             we;
  logic [1:0]       addr;
  logic [BUS_W-1:0] wdata;
  logic             gnt;
  logic [BUS_W-1:0] rdata;

  modport master (output ce, req, we, addr, wdata, input gnt, rdata);
  modport slave  (input ce, req, we, addr, wdata, output gnt, rdata);
endinterface

// File: rtl/gpio_in_debounce.sv
// One-pin debounce filter: the synchronized input must disagree with the
// accepted level for DEBOUNCE_CYCLES consecutive cycles before it is taken.
module gpio_in_debounce
  import gpio_in_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic i_CLK,
  input  logic i_RST,
  input  logic din,
  output logic stable,
  output logic upd
);

  localparam int              CW      = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;

  // upd is the acceptance strobe; the top uses it in the same cycle for edges.
  assign upd = (din != stable) && (cnt == CNT_MAX);

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (din == stable) begin
      cnt <= '0;
    end else if (upd) begin
      stable <= din;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/gpio_in.sv
// Input GPIO responder: synchronizer, per-pin debounce, rise/fall enables,
// W1C pending register and a registered level interrupt.
module gpio_in
  import gpio_in_pkg::*;
#(
  parameter int N_PINS          = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              i_CLK,
  input  logic              i_RST,
  gpio_in_if.slave          bus,
  input  logic [N_PINS-1:0] i_GPIO,
  output logic              o_IRQ
);

  logic [N_PINS-1:0] sync1, sync2;
  logic [N_PINS-1:0] stable, upd;
  logic [N_PINS-1:0] rise_en, fall_en, pend;
  logic [N_PINS-1:0] set_mask, clr_mask, wbits;
  logic              access, wr_en;
  logic              unused_wdata;

  for (genvar g = 0; g < N_PINS; g++) begin : g_pin
    gpio_in_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .i_CLK  (i_CLK),
      .i_RST  (i_RST),
      .din    (sync2[g]),
      .stable (stable[g]),
      .upd    (upd[g])
    );
  end

  assign access       = bus.req & bus.ce;
  assign wr_en        = access & bus.we;
  assign bus.gnt      = access;
  assign wbits        = bus.wdata[N_PINS-1:0];
  assign unused_wdata = ^bus.wdata;

  // sync2 is the value being accepted when upd fires, so it gives the edge direction.
  assign set_mask = upd & ((sync2 & rise_en) | (~sync2 & fall_en));
  assign clr_mask = (wr_en && bus.addr == GPIO_IN_ADDR_PEND) ? wbits : '0;

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      sync1   <= '0;
      sync2   <= '0;
      rise_en <= '0;
      fall_en <= '0;
      pend    <= '0;
      o_IRQ   <= 1'b0;
    end else begin
      sync1 <= i_GPIO;
      sync2 <= sync1;
      if (wr_en && bus.addr == GPIO_IN_ADDR_RISE) rise_en <= wbits;
      if (wr_en && bus.addr == GPIO_IN_ADDR_FALL) fall_en <= wbits;
      // A new edge beats a simultaneous clear of the same bit.
      pend  <= (pend & ~clr_mask) | set_mask;
      o_IRQ <= |pend;
    end
  end

  always_comb begin
    bus.rdata = '0;
    case (bus.addr)
      GPIO_IN_ADDR_DATA: bus.rdata[N_PINS-1:0] = stable;
      GPIO_IN_ADDR_RISE: bus.rdata[N_PINS-1:0] = rise_en;
      GPIO_IN_ADDR_FALL: bus.rdata[N_PINS-1:0] = fall_en;
      default:           bus.rdata[N_PINS-1:0] = pend;
    endcase
  end

endmodule

// File: tb/tb_gpio_in.sv
// Scoreboard bench for gpio_in: directed scenarios plus random pins/bus traffic
// against a behavioural model built on per-pin sample histories.
module tb_gpio_in;
  import gpio_in_pkg::*;

  localparam int N = 8;
  localparam int D = 4;

  logic         i_CLK = 1'b0;
  logic         i_RST;
  logic [N-1:0] gpio;
  logic         irq;

  gpio_in_if bus ();

  gpio_in #(.N_PINS(N), .DEBOUNCE_CYCLES(D)) dut (
    .i_CLK  (i_CLK),
    .i_RST  (i_RST),
    .bus    (bus),
    .i_GPIO (gpio),
    .o_IRQ  (irq)
  );

  always #5 i_CLK = ~i_CLK;

  int n_chk  = 0;
  int n_fail = 0;
  bit started = 1'b0;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } exp_t;
  exp_t sb[$];

  // Reference model: a pin level is accepted once the last D synchronized
  // samples all disagree with the current accepted level.
  logic [N-1:0] m_s1, m_s2, m_stable, m_rise, m_fall, m_pend;
  logic         m_irq;
  logic [D-1:0] hist [N];

  function automatic logic [31:0] model_rd(input logic [1:0] a);
    case (a)
      GPIO_IN_ADDR_DATA: return 32'(m_stable);
      GPIO_IN_ADDR_RISE: return 32'(m_rise);
      GPIO_IN_ADDR_FALL: return 32'(m_fall);
      default:           return 32'(m_pend);
    endcase
  endfunction

  task automatic model_step();
    logic [N-1:0] set_b, clr_b;
    if (i_RST) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_rise = '0; m_fall = '0;
      m_pend = '0; m_irq = 1'b0;
      for (int i = 0; i < N; i++) hist[i] = '0;
      started = 1'b1;
    end else begin
      set_b = '0;
      for (int i = 0; i < N; i++) begin
        hist[i] = {hist[i][D-2:0], m_s2[i]};
        if (hist[i] == {D{~m_stable[i]}}) begin
          m_stable[i] = ~m_stable[i];
          set_b[i] = m_stable[i] ? m_rise[i] : m_fall[i];
        end
      end
      m_irq = |m_pend;
      clr_b = '0;
      if (bus.ce && bus.req && bus.we) begin
        case (bus.addr)
          GPIO_IN_ADDR_RISE: m_rise = bus.wdata[N-1:0];
          GPIO_IN_ADDR_FALL: m_fall = bus.wdata[N-1:0];
          GPIO_IN_ADDR_PEND: clr_b  = bus.wdata[N-1:0];
          default: ;
        endcase
      end
      m_pend = (m_pend & ~clr_b) | set_b;
      m_s2 = m_s1;
      m_s1 = gpio;
    end
  endtask

  initial forever begin
    @(posedge i_CLK);
    model_step();
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every granted read, tracks gnt and irq.
  initial forever begin
    @(negedge i_CLK);
    if (started) begin
      chk("gnt", 32'(bus.gnt), 32'(bus.req & bus.ce));
      chk("irq_model", 32'(irq), 32'(m_irq));
      if (bus.ce && bus.req && !bus.we) begin
        if (sb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL sb_empty: read with no expectation at addr %0d", bus.addr);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk(e.name, bus.rdata, e.exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge i_CLK);
    #1;
  endtask

  task automatic idle();
    bus.ce = 1'b0; bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input bit use_exp,
                    input string nm, input bit ce = 1'b1);
    bus.ce = ce; bus.req = 1'b1; bus.we = 1'b0; bus.addr = a;
    if (ce) sb.push_back('{use_exp ? exp : model_rd(a), nm});
    tick();
    idle();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input bit ce = 1'b1);
    bus.ce = ce; bus.req = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d;
    tick();
    idle();
  endtask

  initial begin
    idle();
    gpio  = 8'hFF;
    i_RST = 1'b1;
    tick(); tick();
    rd(GPIO_IN_ADDR_DATA, 32'h0, 1, "rst_data");
    rd(GPIO_IN_ADDR_RISE, 32'h0, 1, "rst_rise");
    rd(GPIO_IN_ADDR_FALL, 32'h0, 1, "rst_fall");
    rd(GPIO_IN_ADDR_PEND, 32'h0, 1, "rst_pend");
    chk("rst_irq", 32'(irq), 32'h0);

    // First non-reset edge samples the pins; acceptance lands D+1 edges later.
    i_RST = 1'b0;
    repeat (5) tick();
    rd(GPIO_IN_ADDR_DATA, 32'h00, 1, "lat_pre");
    rd(GPIO_IN_ADDR_DATA, 32'hFF, 1, "lat_post");
    gpio = 8'h00;
    repeat (8) tick();

    // Rising interrupt on pin 0 with exact latency
    wr(GPIO_IN_ADDR_RISE, 32'h01);
    gpio[0] = 1'b1;
    repeat (5) tick();
    rd(GPIO_IN_ADDR_PEND, 32'h00, 1, "rise_pend_pre");
    chk("rise_irq_pre", 32'(irq), 32'h0);
    rd(GPIO_IN_ADDR_PEND, 32'h01, 1, "rise_pend");
    chk("rise_irq", 32'(irq), 32'h1);
    wr(GPIO_IN_ADDR_PEND, 32'h01);
    chk("w1c_irq_hold", 32'(irq), 32'h1);
    tick();
    chk("w1c_irq_clr", 32'(irq), 32'h0);
    rd(GPIO_IN_ADDR_PEND, 32'h00, 1, "w1c_pend");

    // Glitch reject on pin 3: 3 cycles rejected, 4 cycles accepted
    wr(GPIO_IN_ADDR_RISE, 32'h09);
    gpio[3] = 1'b1;
    repeat (3) tick();
    gpio[3] = 1'b0;
    repeat (8) tick();
    rd(GPIO_IN_ADDR_DATA, 32'h01, 1, "glitch_data");
    rd(GPIO_IN_ADDR_PEND, 32'h00, 1, "glitch_pend");
    gpio[3] = 1'b1;
    repeat (4) tick();
    gpio[3] = 1'b0;
    repeat (2) tick();
    rd(GPIO_IN_ADDR_DATA, 32'h09, 1, "pulse4_data");
    rd(GPIO_IN_ADDR_PEND, 32'h08, 1, "pulse4_pend");
    repeat (8) tick();
    rd(GPIO_IN_ADDR_DATA, 32'h01, 1, "pulse4_fall");
    wr(GPIO_IN_ADDR_PEND, 32'hFF);

    // Falling-only enable on pin 7
    wr(GPIO_IN_ADDR_RISE, 32'h00);
    wr(GPIO_IN_ADDR_FALL, 32'h80);
    gpio[7] = 1'b1;
    repeat (8) tick();
    rd(GPIO_IN_ADDR_PEND, 32'h00, 1, "fall_after_rise");
    rd(GPIO_IN_ADDR_DATA, 32'h81, 1, "fall_data_hi");
    gpio[7] = 1'b0;
    repeat (8) tick();
    rd(GPIO_IN_ADDR_PEND, 32'h80, 1, "fall_pend");
    wr(GPIO_IN_ADDR_PEND, 32'hFF);

    // Set/clear collision on pin 2
    wr(GPIO_IN_ADDR_RISE, 32'h04);
    wr(GPIO_IN_ADDR_FALL, 32'h00);
    gpio[2] = 1'b1;
    repeat (5) tick();
    wr(GPIO_IN_ADDR_PEND, 32'h04);
    rd(GPIO_IN_ADDR_PEND, 32'h04, 1, "collision_pend");
    wr(GPIO_IN_ADDR_PEND, 32'hFF);
    rd(GPIO_IN_ADDR_PEND, 32'h00, 1, "collision_clr");

    // Bus map behaviour
    wr(GPIO_IN_ADDR_DATA, 32'hFFFF_FFFF);
    rd(GPIO_IN_ADDR_DATA, 32'h05, 1, "data_ro");
    wr(GPIO_IN_ADDR_RISE, 32'hFFFF_FF5A);
    rd(GPIO_IN_ADDR_RISE, 32'h0000_005A, 1, "rise_mask");
    bus.ce = 1'b0; bus.req = 1'b1; bus.we = 1'b1;
    bus.addr = GPIO_IN_ADDR_RISE; bus.wdata = 32'h0;
    #3 chk("gnt_no_ce", 32'(bus.gnt), 32'h0);
    tick();
    idle();
    rd(GPIO_IN_ADDR_RISE, 32'h0000_005A, 1, "no_ce_write");

    // Reset mid-debounce: held-high pins re-qualify after reset
    gpio[5] = 1'b1;
    repeat (2) tick();
    i_RST = 1'b1;
    tick();
    i_RST = 1'b0;
    wr(GPIO_IN_ADDR_RISE, 32'h20);
    repeat (8) tick();
    rd(GPIO_IN_ADDR_DATA, 32'h25, 1, "rst_mid_data");
    rd(GPIO_IN_ADDR_PEND, 32'h20, 1, "rst_mid_pend");

    // Random pins and bus traffic against the model
    for (int it = 0; it < 3000; it++) begin
      int op;
      if ($urandom_range(0, 5) == 0) gpio[$urandom_range(0, N-1)] ^= 1'b1;
      i_RST = ($urandom_range(0, 399) == 0);
      op = $urandom_range(0, 3);
      case (op)
        0: tick();
        1, 3: rd(2'($urandom_range(0, 3)), 32'h0, 0, "rand_rd",
                 $urandom_range(0, 7) != 0);
        default: wr(2'($urandom_range(0, 3)), $urandom,
                    $urandom_range(0, 7) != 0);
      endcase
    end
    i_RST = 1'b0;
    idle();
    repeat (3) tick();

    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
